snn_step_scheduler: RTL and testbench
=====================================

Name: snn_step_scheduler

Overview:
- Time-step sequencer and arbiter for the spiking network datapath.
- Divides the free-running clock into fixed-length simulation time steps.
- At each step boundary, samples the input-neuron spike vector.
- Serialises the pending spikes, round-robin, onto one shared neuron/synapse update port with a valid/ready handshake, so one update engine serves all input neurons.

Parameters:
- N_IN, 3, number of input neurons (spike_in width); legal range 2..16.
- STEP_CYCLES, 16, clock cycles per time step; must be >= N_IN+3.
- IDW, $clog2(N_IN), width of the event id.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  run enable; low freezes the step counter
- spike_in  in  N_IN  raw input spikes, one bit per input neuron
- ev_valid  out  1  event presented to the shared update engine
- ev_id  out  IDW  index of the spiking neuron for the current event
- ev_ready  in  1  update engine accepts the event
- step_tick  out  1  one-cycle pulse on the first cycle of each step
- step_done  out  1  one-cycle pulse when all events of the step have been dispatched
- busy  out  1  high while pending events remain
- overrun  out  1  sticky; a step boundary arrived with events still pending

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All outputs 0; step counter 0; pending vector 0; state IDLE.
  - RR pointer = N_IN-1, so the first grant after reset goes to neuron 0.
  - Reset mid-handshake drops the event; the update engine must tolerate a withdrawn ev_valid only on reset.
- Step counter:
  - Counts 0..STEP_CYCLES-1 and wraps while enable=1; holds its value while enable=0.
  - step_tick=1 in any cycle where the counter is 0 and enable=1.
- FSM states IDLE, SAMPLE, DISPATCH, DONE:
  - IDLE: waits for step_tick.
  - On step_tick, the FSM goes to SAMPLE at the next edge, and pending <= spike_in is captured at that same edge. spike_in is sampled only in the tick cycle.
  - SAMPLE (1 cycle): if pending==0, go to DONE; else go to DISPATCH.
  - DISPATCH:
    - ev_valid=1.
    - ev_id = first set pending bit strictly after the RR pointer, wrapping modulo N_IN.
    - ev_id is stable while ev_valid=1 and ev_ready=0.
    - On ev_valid&ev_ready: clear that pending bit and set RR pointer = ev_id.
    - When the last bit clears, go to DONE.
  - DONE (1 cycle): step_done=1, then go to IDLE.
- busy = (pending != 0).
- Latency: for a single spike with ev_ready held high, ev_valid rises 2 cycles after step_tick and step_done 1 cycle after the handshake. Minimum step turnaround is N_IN+3 cycles.
- Overrun:
  - If step_tick occurs while the FSM is not IDLE, set overrun (sticky until rst).
  - The new sample is discarded; the current dispatch continues unchanged.
  - The next capture happens at the following tick.
- enable=0 mid-step: the counter freezes, dispatch in progress continues to DONE, and no new tick occurs until enable returns.
- The RR pointer persists across steps, giving fairness between steps as well as within a step.
- No combinational path from ev_ready to ev_valid or ev_id.

Optional Feature:
- Macro: SNN_STEP_SPIKE_COUNT_EN.
- Defined:
  - Adds output step_count [IDW:0], the popcount of the vector captured at the tick.
  - Registered; valid from the SAMPLE cycle.
  - Held until the next capture; reset 0.
- Undefined: port absent, no popcount logic.

Decomposition:
- Package snn_pkg holds:
  - the FSM state enum (IDLE, SAMPLE, DISPATCH, DONE);
  - default N_IN and STEP_CYCLES constants;
  - a function rr_next(pending, ptr) returning the next grant index.
- One sub-module, snn_rr_arbiter: combinational round-robin priority picker (pending, ptr -> grant_id, grant_any). The FSM, counters and handshake stay in the top.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then enable=1, spike_in=0 -> all outputs 0 during reset. step_tick every 16 cycles; step_done 2 cycles after each tick; ev_valid never set.
- Round-robin: spike_in=3'b111 at tick, ev_ready=1 -> ev_id sequence 0,1,2 on consecutive cycles starting tick+2; step_done at tick+5. Next step with 3'b101 -> ids 0,2.
- Backpressure: spike_in=3'b110, ev_ready low for 4 cycles then high -> ev_valid=1 and ev_id=1 stable for 4 cycles; then id 1 handshakes, id 2 the next cycle. No id change before handshake.
- Overrun: STEP_CYCLES=16, spike_in=3'b111, ev_ready=0 past the next tick -> overrun=1 at tick+1 and stays 1. The second sample is ignored; after release, exactly 3 events are dispatched.
- Enable freeze: drop enable at counter=5 mid-dispatch -> dispatch completes and step_done pulses. No step_tick while enable=0; the counter resumes at 5 when enable=1.
- Feature (macro defined): spike_in=3'b101 -> step_count=2 from SAMPLE cycle, held until the next tick. Macro undefined: elaboration succeeds without the port.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: state type, default sizing and the round-robin pick function
// shared by the spiking-network step scheduler and its arbiter.
package snn_pkg;

  localparam int N_IN_DEFAULT        = 3;
  localparam int STEP_CYCLES_DEFAULT = 16;
  localparam int MAX_N_IN            = 16;

  typedef enum logic [1:0] {IDLE, SAMPLE, DISPATCH, DONE} state_t;

  // First set bit strictly after ptr, wrapping modulo n; returns ptr when nothing is pending.
  function automatic logic [3:0] rr_next(input logic [MAX_N_IN-1:0] pending,
                                         input logic [3:0]          ptr,
                                         input int                  n);
    logic [3:0] grant;
    logic [3:0] idx;
    logic       found;
    grant = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_N_IN; k++) begin
      idx = 4'((int'(ptr) + k) % n);
      if (!found && (k <= n) && pending[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// snn_rr_arbiter: combinational round-robin picker; grants the first pending
// neuron strictly after the last-served pointer.
module snn_rr_arbiter
  import snn_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT,
  parameter int IDW  = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] pending,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  assign grant_id  = IDW'(rr_next(MAX_N_IN'(pending), 4'(ptr), N_IN));
  assign grant_any = |pending;

endmodule

// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler: slices the clock into time steps, captures spike_in at each
// step boundary and serialises the spikes round-robin onto one valid/ready port.
// Optional macro SNN_STEP_SPIKE_COUNT_EN adds step_count (popcount of each capture).
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int N_IN        = N_IN_DEFAULT,
  parameter int STEP_CYCLES = STEP_CYCLES_DEFAULT,
  parameter int IDW         = $clog2(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [N_IN-1:0] spike_in,
  output logic            ev_valid,
  output logic [IDW-1:0]  ev_id,
  input  logic            ev_ready,
  output logic            step_tick,
  output logic            step_done,
  output logic            busy,
  output logic            overrun
`ifdef SNN_STEP_SPIKE_COUNT_EN
  ,
  output logic [IDW:0]    step_count
`endif
);

  localparam int             CW        = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [IDW-1:0] PTR_RESET = IDW'(N_IN - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   step_cnt;
  logic [N_IN-1:0] pending;
  logic [N_IN-1:0] pending_clr;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic            handshake;
  logic            capture;

  snn_rr_arbiter #(
    .N_IN (N_IN),
    .IDW  (IDW)
  ) u_arb (
    .pending   (pending),
    .ptr       (rr_ptr),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Gated by rst so no tick is reported while reset is held.
  assign step_tick   = enable && !rst && (step_cnt == '0);
  assign capture     = (state == IDLE) && step_tick;
  assign busy        = |pending;
  assign handshake   = ev_valid && ev_ready;
  assign pending_clr = pending & ~(N_IN'(1) << grant_id);

  always_comb begin
    state_nxt = state;
    ev_valid  = 1'b0;
    ev_id     = '0;
    step_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (step_tick) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        state_nxt = (pending == '0) ? DONE : DISPATCH;
      end
      DISPATCH: begin
        ev_valid = grant_any;
        ev_id    = grant_id;
        if (!grant_any || (handshake && (pending_clr == '0))) state_nxt = DONE;
      end
      DONE: begin
        step_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A tick outside IDLE only flags overrun; the sample is dropped and dispatch carries on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step_cnt <= '0;
      pending  <= '0;
      rr_ptr   <= PTR_RESET;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (enable) step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + CW'(1);
      if (capture) begin
        pending <= spike_in;
      end else if (handshake) begin
        pending <= pending_clr;
        rr_ptr  <= grant_id;
      end
      if (step_tick && (state != IDLE)) overrun <= 1'b1;
    end
  end

`ifdef SNN_STEP_SPIKE_COUNT_EN
  localparam int SCW = IDW + 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_count <= '0;
    end else if (capture) begin
      step_count <= SCW'($countones(spike_in));
    end
  end
`endif

endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb_snn_step_scheduler: randomized and directed stimulus with a queue-based
// scoreboard; expected event order is derived from the captured vector at each tick.
module tb_snn_step_scheduler;

  localparam int N_IN        = 3;
  localparam int STEP_CYCLES = 16;
  localparam int IDW         = $clog2(N_IN);

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            ev_ready;
  logic [N_IN-1:0] spike_in;
  logic            ev_valid;
  logic [IDW-1:0]  ev_id;
  logic            step_tick;
  logic            step_done;
  logic            busy;
  logic            overrun;
`ifdef SNN_STEP_SPIKE_COUNT_EN
  logic [IDW:0]    step_count;
  int              exp_count = 0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];
  int cycle        = 0;
  int model_cnt    = 0;
  int model_ptr    = N_IN - 1;
  int exp_done     = -10;
  int sample_cycle = -10;
  bit exp_overrun  = 1'b0;
  int captures     = 0;
  int done_seen    = 0;
  bit prev_stall   = 1'b0;
  int prev_id      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  snn_step_scheduler #(
    .N_IN        (N_IN),
    .STEP_CYCLES (STEP_CYCLES),
    .IDW         (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .spike_in  (spike_in),
    .ev_valid  (ev_valid),
    .ev_id     (ev_id),
    .ev_ready  (ev_ready),
    .step_tick (step_tick),
    .step_done (step_done),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SNN_STEP_SPIKE_COUNT_EN
    ,
    .step_count(step_count)
`endif
  );

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Events of a step are served in cyclic order starting just after the last-served neuron.
  task automatic capture_model(input logic [N_IN-1:0] spikes, input int tick_cycle);
    int n;
    int idx;
    n = 0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = (model_ptr + k) % N_IN;
      if (spikes[idx]) begin
        exp_q.push_back(idx);
        n++;
      end
    end
    if (n > 0) model_ptr = exp_q[exp_q.size() - 1];
    else exp_done = tick_cycle + 2;
    sample_cycle = tick_cycle + 1;
    captures++;
`ifdef SNN_STEP_SPIKE_COUNT_EN
    exp_count = n;
`endif
  endtask

  task automatic run_cycle();
    bit              exp_tick;
    bit              do_capture;
    bit              do_ovr;
    logic [N_IN-1:0] snap;
    int              c;
    #1;
    c          = cycle;
    do_capture = 1'b0;
    do_ovr     = 1'b0;
    snap       = spike_in;
    exp_tick   = enable && (model_cnt == 0);
    check("step_tick", int'(step_tick), int'(exp_tick));
    if (exp_tick) begin
      if ((exp_q.size() == 0) && (c > exp_done)) do_capture = 1'b1;
      else do_ovr = 1'b1;
    end
    @(posedge clk);
    if (enable) model_cnt = (model_cnt + 1) % STEP_CYCLES;
    if (do_capture) capture_model(snap, c);
    if (do_ovr) exp_overrun = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [N_IN-1:0] spikes, input int ready_from,
                                input bit rnd_ready);
    for (int o = 0; o < STEP_CYCLES; o++) begin
      spike_in = (o == 0) ? spikes : N_IN'($urandom);
      if (rnd_ready) ev_ready = (o >= 10) || ($urandom_range(0, 3) != 0);
      else ev_ready = (o >= ready_from);
      run_cycle();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    enable   = 1'b0;
    ev_ready = 1'b0;
    spike_in = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ev_valid", int'(ev_valid), 0);
    check("rst_ev_id", int'(ev_id), 0);
    check("rst_step_tick", int'(step_tick), 0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    exp_q.delete();
    model_cnt    = 0;
    model_ptr    = N_IN - 1;
    exp_done     = -10;
    sample_cycle = -10;
    exp_overrun  = 1'b0;
`ifdef SNN_STEP_SPIKE_COUNT_EN
    exp_count    = 0;
`endif
    @(negedge clk);
  endtask

  // Monitor samples 2 time units after the falling edge, once the driver's inputs have settled.
  always @(negedge clk) begin : monitor
    int e;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("busy", int'(busy), int'(exp_q.size() != 0));
      check("ev_valid", int'(ev_valid), int'((exp_q.size() != 0) && (cycle != sample_cycle)));
      check("step_done", int'(step_done), int'(cycle == exp_done));
      check("overrun", int'(overrun), int'(exp_overrun));
`ifdef SNN_STEP_SPIKE_COUNT_EN
      check("step_count", int'(step_count), exp_count);
`endif
      if (prev_stall) check("stall_id_stable", int'(ev_id), prev_id);
      if (step_done) begin
        check("done_drained", exp_q.size(), 0);
        done_seen++;
      end
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_event", int'(ev_id), -1);
        end else begin
          e = exp_q.pop_front();
          check("ev_id", int'(ev_id), e);
          if (exp_q.size() == 0) exp_done = cycle + 1;
        end
      end
      prev_stall = ev_valid && !ev_ready;
      prev_id    = int'(ev_id);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    ev_ready = 1'b0;
    spike_in = '0;
    @(negedge clk);
    do_reset();
    rst    = 1'b0;
    enable = 1'b1;

    apply_stimulus(3'b000, 0, 1'b0);
    apply_stimulus(3'b000, 0, 1'b0);
    apply_stimulus(3'b111, 0, 1'b0);
    apply_stimulus(3'b101, 0, 1'b0);
    apply_stimulus(3'b110, 6, 1'b0);

    repeat (40) apply_stimulus(N_IN'($urandom), 0, 1'b1);

    // Freeze the counter at 5 while a stalled dispatch is still in flight.
    ev_ready = 1'b0;
    spike_in = 3'b111;
    for (int o = 0; o < 5; o++) begin
      run_cycle();
      spike_in = N_IN'($urandom);
    end
    enable   = 1'b0;
    ev_ready = 1'b1;
    repeat (20) begin
      spike_in = N_IN'($urandom);
      run_cycle();
    end
    enable = 1'b1;
    repeat (STEP_CYCLES - 5) begin
      spike_in = N_IN'($urandom);
      run_cycle();
    end
    apply_stimulus(3'b010, 0, 1'b0);

    apply_stimulus(3'b111, 99, 1'b0);
    apply_stimulus(3'b011, 3, 1'b0);
    apply_stimulus(3'b000, 0, 1'b0);

    check("done_count", done_seen, captures);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
